pwm_reg_arbiter: RTL and testbench

Owns the PWM configuration register bank: output enables, PWM enables and duty cycle. Arbitrates write access to it among several requesters, such as the SPI peripheral's decoded writes and an on-chip sequencer. Arbitration is round-robin, one write per cycle, with an optional lock that lets one requester issue an uninterrupted multi-write burst. Sits between the write sources and the PWM generator, which reads the five register outputs directly.

---
 rtl/pwm_reg_arbiter.sv | 162 ++++++++++++++++
 tb/tb_pwm_reg_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter: round-robin write arbiter with burst lock for the PWM
// config register bank (out enables, pwm enables, duty cycle at addr 0..4).
// Ports: clk, rst_n (async low); req_valid/req_lock/req_addr/req_data per
// requester; req_ready one-hot grant; wr_err pulse; locked/lock_owner;
// five 8-bit register outputs read directly by the PWM generator.
module pwm_reg_arbiter #(
  parameter int         NUM_REQ     = 2,
  parameter logic [2:0] MAX_ADDRESS = 3'h4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [3*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 wr_err,
  output logic                 locked,
  output logic [1:0]           lock_owner,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      own_q, own_d;
  logic            err_q, err_d;
  logic [4:0][7:0] regs_q, regs_d;

  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         gidx;
  logic               found;
  logic [2:0]         idx;
  logic               own_lock;
  logic               glock;
  logic [2:0]         waddr;
  logic [7:0]         wdata;
  logic               wr_en;
  logic               in_rng;

  function automatic logic [1:0] nxt(input logic [1:0] g);
    if (g == 2'(NUM_REQ - 1)) return 2'd0;
    return g + 2'd1;
  endfunction

  // Grant selection: rotating search in IDLE, owner only in LOCKED.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    unique case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = {1'b0, rr_q} + 3'(k);
          if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
          for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && idx == 3'(j) && req_valid[j]) begin
              found  = 1'b1;
              gnt[j] = 1'b1;
              gidx   = 2'(j);
            end
          end
        end
      end
      LOCKED: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (own_q == 2'(j)) begin
            gnt[j] = req_valid[j];
            gidx   = 2'(j);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    own_lock = 1'b0;
    glock    = 1'b0;
    waddr    = '0;
    wdata    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (own_q == 2'(j)) own_lock = req_lock[j];
      if (gnt[j]) begin
        glock = req_lock[j];
        waddr = req_addr[3*j +: 3];
        wdata = req_data[8*j +: 8];
      end
    end
  end

  assign wr_en  = |gnt;
  // Bank has five entries; upper codes must never alias.
  assign in_rng = (waddr <= MAX_ADDRESS) && (waddr <= 3'd4);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    err_d   = 1'b0;
    regs_d  = regs_q;
    if (wr_en) begin
      if (in_rng) regs_d[waddr] = wdata;
      else        err_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          rr_d = nxt(gidx);
          if (glock) begin
            state_d = LOCKED;
            own_d   = gidx;
          end
        end
      end
      LOCKED: begin
        // Release on any cycle the owner drops lock, write or not.
        if (!own_lock) begin
          state_d = IDLE;
          rr_d    = nxt(own_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      err_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  assign req_ready       = gnt & {NUM_REQ{rst_n}};
  assign wr_err          = err_q;
  assign locked          = (state_q == LOCKED);
  assign lock_owner      = own_q;
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// tb_pwm_reg_arbiter: directed bench for pwm_reg_arbiter with a scoreboard
// of expected post-edge bank/flag state, popped after each clock edge.
module tb_pwm_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_lock, req_ready;
  logic [5:0] req_addr;
  logic [15:0] req_data;
  logic       wr_err, locked;
  logic [1:0] lock_owner;
  logic [7:0] r0, r1, r2, r3, r4;

  pwm_reg_arbiter #(.NUM_REQ(2), .MAX_ADDRESS(3'h4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_err(wr_err),
    .locked(locked), .lock_owner(lock_owner),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1),
    .en_reg_pwm_7_0(r2), .en_reg_pwm_15_8(r3),
    .pwm_duty_cycle(r4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][7:0] regs;
    logic            err;
    logic            lk;
    logic [1:0]      own;
  } exp_t;

  exp_t            sb_q[$];
  logic [4:0][7:0] m_regs;
  int              n_chk = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v0, input logic l0, input logic [2:0] a0,
                     input logic [7:0] d0, input logic v1, input logic l1,
                     input logic [2:0] a1, input logic [7:0] d1);
    req_valid = {v1, v0};
    req_lock  = {l1, l0};
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic chk_regs(input string tag, input logic [4:0][7:0] e);
    check({tag, "_r0"}, 32'(r0), 32'(e[0]));
    check({tag, "_r1"}, 32'(r1), 32'(e[1]));
    check({tag, "_r2"}, 32'(r2), 32'(e[2]));
    check({tag, "_r3"}, 32'(r3), 32'(e[3]));
    check({tag, "_r4"}, 32'(r4), 32'(e[4]));
  endtask

  // Called at a falling edge with inputs driven; returns at next falling edge.
  task automatic cyc(input string tag, input logic [1:0] exp_rdy,
                     input logic exp_lk, input logic [1:0] exp_own);
    exp_t e;
    logic [2:0] a;
    e.err = 1'b0;
    for (int g = 0; g < 2; g++) begin
      if (exp_rdy[g] && req_valid[g]) begin
        a = req_addr[3*g +: 3];
        if (a <= 3'd4) m_regs[a] = req_data[8*g +: 8];
        else           e.err = 1'b1;
      end
    end
    e.regs = m_regs;
    e.lk   = exp_lk;
    e.own  = exp_own;
    sb_q.push_back(e);
    #1;
    check({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_regs(tag, e.regs);
    check({tag, "_err"}, 32'(wr_err), 32'(e.err));
    check({tag, "_lk"}, 32'(locked), 32'(e.lk));
    check({tag, "_own"}, 32'(lock_owner), 32'(e.own));
    @(negedge clk);
  endtask

  initial begin
    m_regs = '0;
    rst_n  = 1'b0;
    drv(1, 0, 3'd4, 8'h11, 0, 0, 3'd0, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(req_ready), 32'h0);
    chk_regs("rst", m_regs);
    check("rst_err", 32'(wr_err), 32'h0);
    check("rst_lk", 32'(locked), 32'h0);
    check("rst_own", 32'(lock_owner), 32'h0);
    drv(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    drv(1, 0, 3'd4, 8'h80, 0, 0, 3'd0, 8'h00);
    cyc("first", 2'b01, 0, 2'd0);

    drv(0, 0, 3'd0, 8'h00, 1, 0, 3'd3, 8'h11);
    cyc("prep1", 2'b10, 0, 2'd0);
    drv(1, 0, 3'd0, 8'hA5, 1, 0, 3'd1, 8'h5A);
    cyc("rr0", 2'b01, 0, 2'd0);
    cyc("rr1", 2'b10, 0, 2'd0);
    cyc("rr2", 2'b01, 0, 2'd0);
    cyc("rr3", 2'b10, 0, 2'd0);

    drv(1, 0, 3'd0, 8'h77, 0, 0, 3'd0, 8'h00);
    cyc("prep2", 2'b01, 0, 2'd0);
    drv(1, 0, 3'd0, 8'h77, 1, 1, 3'd2, 8'h0F);
    cyc("bst0", 2'b10, 1, 2'd1);
    drv(1, 0, 3'd0, 8'h77, 1, 1, 3'd3, 8'hF0);
    cyc("bst1", 2'b10, 1, 2'd1);
    drv(1, 0, 3'd0, 8'h77, 1, 0, 3'd4, 8'h33);
    cyc("bst2", 2'b10, 0, 2'd1);
    drv(1, 0, 3'd0, 8'h77, 0, 0, 3'd0, 8'h00);
    cyc("bst3", 2'b01, 0, 2'd1);

    drv(0, 0, 3'd0, 8'h00, 1, 0, 3'd5, 8'hFF);
    cyc("oor5", 2'b10, 0, 2'd1);
    drv(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    cyc("oor5i", 2'b00, 0, 2'd1);
    drv(1, 0, 3'd7, 8'hFF, 0, 0, 3'd0, 8'h00);
    cyc("oor7", 2'b01, 0, 2'd1);
    drv(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    cyc("oor7i", 2'b00, 0, 2'd1);

    drv(1, 1, 3'd0, 8'h01, 0, 0, 3'd0, 8'h00);
    cyc("wd0", 2'b01, 1, 2'd0);
    drv(1, 1, 3'd1, 8'h02, 1, 0, 3'd2, 8'hEE);
    cyc("wd1", 2'b01, 1, 2'd0);
    drv(0, 1, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    cyc("wd2", 2'b00, 1, 2'd0);
    drv(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    cyc("wd3", 2'b00, 0, 2'd0);
    drv(1, 0, 3'd0, 8'h03, 1, 0, 3'd2, 8'h44);
    cyc("wd4", 2'b10, 0, 2'd0);

    drv(1, 1, 3'd3, 8'h55, 0, 0, 3'd0, 8'h00);
    cyc("mb0", 2'b01, 1, 2'd0);
    drv(1, 1, 3'd4, 8'h66, 0, 0, 3'd0, 8'h00);
    cyc("mb1", 2'b01, 1, 2'd0);
    drv(1, 1, 3'd0, 8'h99, 0, 0, 3'd0, 8'h00);
    #2;
    rst_n  = 1'b0;
    m_regs = '0;
    #1;
    check("mb_rst_rdy", 32'(req_ready), 32'h0);
    check("mb_rst_lk", 32'(locked), 32'h0);
    check("mb_rst_own", 32'(lock_owner), 32'h0);
    chk_regs("mb_rst", m_regs);
    @(posedge clk);
    #1;
    chk_regs("mb_hold", m_regs);
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 0, 3'd0, 8'h00, 1, 0, 3'd1, 8'h21);
    cyc("mb_r1", 2'b10, 0, 2'd0);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
